// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight destination registers for the
// stages between ID and WB, flags RAW dependencies of the instruction in ID,
// and counts stall cycles with a saturating counter.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 4,
   parameter int NUM_STAGES = 2,
   parameter int FWD_EN     = 0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic                  with_src1,
   input  logic                  with_src2,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  id_wb_en,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_dest,
   output logic                  has_hazard,
   output logic [NUM_STAGES-1:0] hazard_stage,
   output logic [CNT_W-1:0]      stall_count
);

   // Scoreboard entries, index 0 = EXE, index NUM_STAGES-1 = last stage before WB
   logic [NUM_STAGES-1:0] r_valid;
   logic [NUM_STAGES-1:0] r_wb_en;
   logic [NUM_STAGES-1:0] r_mem_read;
   logic [REG_ADDR_W-1:0] r_dest [NUM_STAGES];
   logic [CNT_W-1:0]      r_stall_cnt;

   logic [NUM_STAGES-1:0] w_stage_raw;
   logic                  w_id_live;
   logic                  w_insert;

   // Per-stage operand compare; with forwarding only a load sitting in EXE
   // can still cause a stall, everything else is bypassed.
   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
         logic w_m1;
         logic w_m2;
         assign w_m1 = with_src1 & r_valid[gi] & r_wb_en[gi] & (src1 == r_dest[gi]);
         assign w_m2 = with_src2 & r_valid[gi] & r_wb_en[gi] & (src2 == r_dest[gi]);
         if (FWD_EN != 0) begin : g_fwd
            if (gi == 0) begin : g_exe
               assign w_stage_raw[gi] = (w_m1 | w_m2) & r_mem_read[gi];
            end else begin : g_late
               assign w_stage_raw[gi] = 1'b0;
            end
         end else begin : g_nofwd
            assign w_stage_raw[gi] = w_m1 | w_m2;
         end
      end
   endgenerate

   // A squashed or empty ID slot never requests a stall
   assign w_id_live    = id_valid & ~flush;
   assign hazard_stage = w_stage_raw & {NUM_STAGES{w_id_live}};
   assign has_hazard   = |hazard_stage;
   assign w_insert     = w_id_live & ~has_hazard;
   assign stall_count  = r_stall_cnt;

   // Shift the scoreboard one stage per unfrozen clock, injecting the ID
   // instruction or a bubble into stage 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         r_wb_en    <= '0;
         r_mem_read <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            r_dest[i] <= '0;
         end
      end else if (!freeze) begin
         r_valid[0]    <= w_insert;
         r_wb_en[0]    <= w_insert & id_wb_en;
         r_mem_read[0] <= w_insert & id_mem_read;
         r_dest[0]     <= w_insert ? id_dest : '0;
         for (int i = 1; i < NUM_STAGES; i++) begin
            r_valid[i]    <= r_valid[i-1];
            r_wb_en[i]    <= r_wb_en[i-1];
            r_mem_read[i] <= r_mem_read[i-1];
            r_dest[i]     <= r_dest[i-1];
         end
      end
   end

   // Saturating count of cycles in which a stall was actually taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (!freeze && has_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances share one stimulus
// stream (no forwarding, forwarding, and an 8-stage 4-bit-counter variant).
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst, freeze, flush, id_valid, with_src1, with_src2;
   logic [3:0] src1, src2, id_dest;
   logic       id_wb_en, id_mem_read;

   logic        ns_haz, fw_haz, sat_haz;
   logic [1:0]  ns_stage, fw_stage;
   logic [7:0]  sat_stage;
   logic [15:0] ns_cnt, fw_cnt;
   logic [3:0]  sat_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_ADDR_W(4), .NUM_STAGES(2), .FWD_EN(0), .CNT_W(16)) u_ns (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
      .with_src1(with_src1), .with_src2(with_src2), .src1(src1), .src2(src2),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
      .has_hazard(ns_haz), .hazard_stage(ns_stage), .stall_count(ns_cnt));

   hazard_scoreboard #(.REG_ADDR_W(4), .NUM_STAGES(2), .FWD_EN(1), .CNT_W(16)) u_fw (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
      .with_src1(with_src1), .with_src2(with_src2), .src1(src1), .src2(src2),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
      .has_hazard(fw_haz), .hazard_stage(fw_stage), .stall_count(fw_cnt));

   hazard_scoreboard #(.REG_ADDR_W(4), .NUM_STAGES(8), .FWD_EN(0), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
      .with_src1(with_src1), .with_src2(with_src2), .src1(src1), .src2(src2),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dest(id_dest),
      .has_hazard(sat_haz), .hazard_stage(sat_stage), .stall_count(sat_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      freeze = 0; flush = 0; id_valid = 0; with_src1 = 0; with_src2 = 0;
      src1 = 0; src2 = 0; id_wb_en = 0; id_mem_read = 0; id_dest = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      #1;
   endtask

   initial begin
      rst = 1;
      idle_inputs();

      // Reset with a live reader on the ID inputs
      id_valid = 1; with_src1 = 1; src1 = 3; id_wb_en = 1; id_dest = 3;
      step(); step();
      rst = 0;
      #1;
      chk("rst_haz",   32'(ns_haz),   32'h0);
      chk("rst_stage", 32'(ns_stage), 32'h0);
      chk("rst_cnt",   32'(ns_cnt),   32'h0);
      chk("self_dest", 32'(ns_haz),   32'h0);
      step();
      chk("own_dest_next", 32'(ns_haz), 32'h1);

      // Writer then dependent reader, no forwarding: 2 stall cycles
      do_reset();
      id_valid = 1; id_wb_en = 1; id_dest = 5;
      #1;
      chk("ns_c0_haz", 32'(ns_haz), 32'h0);
      step();
      id_wb_en = 0; id_dest = 0; with_src1 = 1; src1 = 5;
      #1;
      chk("ns_c1_haz",   32'(ns_haz),   32'h1);
      chk("ns_c1_stage", 32'(ns_stage), 32'h1);
      chk("fw_nonload",  32'(fw_haz),   32'h0);
      step();
      chk("ns_c2_haz",   32'(ns_haz),   32'h1);
      chk("ns_c2_stage", 32'(ns_stage), 32'h2);
      step();
      chk("ns_c3_haz", 32'(ns_haz), 32'h0);
      chk("ns_c3_cnt", 32'(ns_cnt), 32'd2);

      // Load followed by src2 reader, forwarding: exactly 1 stall cycle
      do_reset();
      id_valid = 1; id_wb_en = 1; id_mem_read = 1; id_dest = 7;
      step();
      id_wb_en = 0; id_mem_read = 0; id_dest = 0; with_src2 = 1; src2 = 7;
      #1;
      chk("fw_c1_haz",   32'(fw_haz),   32'h1);
      chk("fw_c1_stage", 32'(fw_stage), 32'h1);
      step();
      chk("fw_c2_haz",    32'(fw_haz),   32'h0);
      chk("fw_c2_stage",  32'(fw_stage), 32'h0);
      chk("fw_cnt",       32'(fw_cnt),   32'd1);
      chk("ns_c2_load",   32'(ns_stage), 32'h2);

      // Freeze held 3 cycles with a pending hazard
      do_reset();
      id_valid = 1; id_wb_en = 1; id_dest = 5;
      step();
      id_wb_en = 0; id_dest = 0; with_src1 = 1; src1 = 5;
      freeze = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("frz_haz",   32'(ns_haz),   32'h1);
         chk("frz_stage", 32'(ns_stage), 32'h1);
         chk("frz_cnt",   32'(ns_cnt),   32'h0);
      end
      freeze = 0;
      step();
      chk("unfrz_stage", 32'(ns_stage), 32'h2);
      chk("unfrz_cnt",   32'(ns_cnt),   32'd1);
      // Reset beats freeze and discards the pending entry
      freeze = 1; rst = 1;
      step();
      rst = 0; freeze = 0;
      #1;
      chk("rst_mid_haz", 32'(ns_haz), 32'h0);
      chk("rst_mid_cnt", 32'(ns_cnt), 32'h0);

      // Flush wins over a matching source; squashed writer is not recorded
      do_reset();
      id_valid = 1; id_wb_en = 1; id_dest = 5;
      step();
      with_src1 = 1; src1 = 5; id_wb_en = 1; id_dest = 4; flush = 1;
      #1;
      chk("flush_haz",   32'(ns_haz),   32'h0);
      chk("flush_stage", 32'(ns_stage), 32'h0);
      step();
      flush = 0; id_wb_en = 0; id_dest = 0; src1 = 4;
      #1;
      chk("squashed_dest", 32'(ns_haz), 32'h0);
      src1 = 5;
      #1;
      chk("flush_old_stage", 32'(ns_stage), 32'h2);
      chk("flush_cnt",       32'(ns_cnt),   32'h0);

      // Self-dependent stream on 8 stages: 4-bit counter saturates at 15
      do_reset();
      id_valid = 1; with_src1 = 1; src1 = 5; id_wb_en = 1; id_dest = 5;
      for (int k = 0; k < 9; k++) step();
      chk("sat_cnt8", 32'(sat_cnt), 32'd8);
      chk("sat_gap",  32'(sat_haz), 32'h0);
      step();
      with_src1 = 0;
      #1;
      chk("sat_nosrc", 32'(sat_haz), 32'h0);
      with_src1 = 1;
      #1;
      chk("sat_stage0", 32'(sat_stage), 32'h01);
      for (int k = 0; k < 6; k++) step();
      chk("sat_cnt14", 32'(sat_cnt), 32'd14);
      for (int k = 0; k < 4; k++) step();
      chk("sat_cnt15", 32'(sat_cnt), 32'd15);
      for (int k = 0; k < 10; k++) step();
      chk("sat_nowrap", 32'(sat_cnt), 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector.
- Holds a shift-register scoreboard of in-flight destination registers for the NUM_STAGES pipeline stages between ID and WB. The scoreboard is fed by the ID stage and advanced every unfrozen clock.
- Raises has_hazard when an ID source operand depends on a pending write.
- Supports two modes: full-stall (no forwarding) and load-use-only (forwarding present).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 4, width of register index.
- NUM_STAGES, 2, tracked stages after ID (stage 0 = EXE, stage 1 = MEM, ...). Legal range 1..8.
- FWD_EN, 0, 0 = stall on any pending write match; 1 = stall only on load-use match in stage 0.
- CNT_W, 16, width of stall_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- freeze  input  1  global pipeline freeze (memory wait); scoreboard and counter hold.
- flush  input  1  squash current ID instruction (taken branch).
- id_valid  input  1  ID holds a real instruction.
- with_src1  input  1  instruction reads src1.
- with_src2  input  1  instruction reads src2.
- src1  input  REG_ADDR_W  first source index.
- src2  input  REG_ADDR_W  second source index.
- id_wb_en  input  1  ID instruction writes back.
- id_mem_read  input  1  ID instruction is a load.
- id_dest  input  REG_ADDR_W  ID destination index.
- has_hazard  output  1  stall request to IF/ID; combinational.
- hazard_stage  output  NUM_STAGES  one-hot/multi-hot of stages causing the hazard; combinational.
- stall_count  output  CNT_W  saturating count of hazard cycles; registered.

Behaviour:
- Scoreboard entry per stage: {valid, wb_en, mem_read, dest}. Stage i+1 receives stage i each unfrozen cycle. The entry leaving stage NUM_STAGES-1 is discarded, i.e. committed at WB.
- Insert into stage 0 on each unfrozen edge:
  - Bubble (valid=0, wb_en=0, mem_read=0, dest=0) if has_hazard=1, flush=1 or id_valid=0.
  - Otherwise {1, id_wb_en, id_mem_read, id_dest}.
- Reset: all entries cleared; stall_count=0. With an empty scoreboard, has_hazard=0 and hazard_stage=0.
- rst has priority over freeze and flush. Reset mid-operation discards all pending entries on that edge.
- freeze=1: entries and stall_count hold. has_hazard is still evaluated from the held state.
- Stage match, per stage i:
  - m1_i = with_src1 & valid_i & wb_en_i & (src1 == dest_i).
  - m2_i = with_src2 & valid_i & wb_en_i & (src2 == dest_i).
- FWD_EN=0: hazard_stage[i] = m1_i | m2_i for every i.
- FWD_EN=1: hazard_stage[0] = (m1_0 | m2_0) & mem_read_0; hazard_stage[i>0] = 0.
- has_hazard = id_valid & ~flush & (|hazard_stage). hazard_stage is also gated by id_valid & ~flush.
- Same-cycle write: a stage holding the ID's own dest (e.g. src1 == id_dest) does not self-hazard. Only scoreboard entries are compared.
- Multiple matching stages set multiple hazard_stage bits. has_hazard deasserts only once the last matching entry shifts out.
- Latency:
  - Non-forwarding, dependent instruction directly behind a writer: stalls NUM_STAGES cycles.
  - Forwarding, load-use: stalls exactly 1 cycle.
- stall_count increments by 1 on each unfrozen edge with has_hazard=1. It saturates at 2^CNT_W-1 and does not wrap.
- Flush during hazard: flush wins; has_hazard=0 and a bubble is inserted.
- Index width: full REG_ADDR_W compare. No register is special-cased.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with id_valid=1, src1=3 -> has_hazard=0, hazard_stage=0, stall_count=0 after release.
- FWD_EN=0, NUM_STAGES=2:
  - Stimulus: cycle0 writer id_wb_en=1, id_dest=5; cycle1 reader src1=5, with_src1=1.
  - Required: has_hazard=1 in cycles 1–2 with hazard_stage=01 then 10; 0 in cycle 3; stall_count=2.
- FWD_EN=1:
  - Stimulus: load (id_mem_read=1, dest=7) followed by a reader of src2=7 with with_src2=1.
  - Required: exactly 1 hazard cycle.
  - Repeat with id_mem_read=0: no hazard.
- freeze=1 held 3 cycles while a hazard is pending -> has_hazard stays 1, hazard_stage unchanged, stall_count unchanged. On release, the shift resumes.
- flush=1 with a matching src -> has_hazard=0. The squashed ID writer (dest=4) is not recorded; a later src1=4 reader sees no hazard.
- CNT_W=4:
  - Stimulus: force a continuous hazard for 20 cycles by holding a writer entry with freeze pulsed low.
  - Required: stall_count saturates at 15 with no wrap. A with_src1=0 reader with src1 == dest shows no hazard.
